// File: rtl/ioctl_sdram_loader.sv
// ioctl download responder: turns each qualifying 16-bit ioctl word into one SDRAM write request.
// Optional build macro: IOCTL_LOADER_BYTESWAP_EN swaps the two bytes of every stored word.
module ioctl_sdram_loader #(
    parameter int               ADDR_W     = 25,
    parameter logic [7:0]       LOAD_INDEX = 8'h00,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [15:0]       ioctl_dout,
    output logic              ioctl_wait,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    input  logic              mem_ack,
    output logic              loading,
    output logic              done,
    output logic [23:0]       word_count,
    output logic              overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_BUSY,
        S_FINISH
    } state_t;

    state_t state, state_nxt;

    logic              wait_nxt;
    logic              req_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [15:0]       din_nxt;
    logic              loading_nxt;
    logic              done_nxt;
    logic [23:0]       count_nxt;
    logic              overrun_nxt;

    logic              index_hit;
    logic              strobe;
    logic [ADDR_W-1:0] addr_sum;
    logic [ADDR_W-1:0] wr_addr;
    logic [15:0]       wr_data;

    assign index_hit = (ioctl_index == LOAD_INDEX);
    assign strobe    = ioctl_download & ioctl_wr & index_hit;

    // Sum wraps modulo 2^ADDR_W; bit 0 is forced low so every request is word aligned.
    assign addr_sum  = BASE_ADDR + ioctl_addr;
    assign wr_addr   = {addr_sum[ADDR_W-1:1], 1'b0};

`ifdef IOCTL_LOADER_BYTESWAP_EN
    assign wr_data = {ioctl_dout[7:0], ioctl_dout[15:8]};
`else
    assign wr_data = ioctl_dout;
`endif

    // NOTE: every variable gets its hold value before the case so no path leaves one unassigned (no latch).
    always_comb begin
        state_nxt   = state;
        wait_nxt    = ioctl_wait;
        req_nxt     = mem_req;
        addr_nxt    = mem_addr;
        din_nxt     = mem_din;
        count_nxt   = word_count;
        overrun_nxt = overrun;
        done_nxt    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (ioctl_download && index_hit) begin
                    state_nxt   = S_LOAD;
                    count_nxt   = '0;
                    overrun_nxt = 1'b0;
                end
            end

            S_LOAD: begin
                if (strobe) begin
                    state_nxt = S_BUSY;
                    addr_nxt  = wr_addr;
                    din_nxt   = wr_data;
                    req_nxt   = 1'b1;
                    wait_nxt  = 1'b1;
                end else if (!ioctl_download) begin
                    state_nxt = S_FINISH;
                    done_nxt  = 1'b1;
                end
            end

            S_BUSY: begin
                // A sender ignoring ioctl_wait loses its word; only the flag records it.
                if (strobe) begin
                    overrun_nxt = 1'b1;
                end
                if (mem_ack) begin
                    req_nxt  = 1'b0;
                    wait_nxt = 1'b0;
                    if (word_count != '1) begin
                        count_nxt = word_count + 24'd1;
                    end
                    if (ioctl_download) begin
                        state_nxt = S_LOAD;
                    end else begin
                        state_nxt = S_FINISH;
                        done_nxt  = 1'b1;
                    end
                end
            end

            S_FINISH: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        loading_nxt = (state_nxt != S_IDLE);
    end

    // NOTE: state and outputs are registered with non-blocking assignments; reset clears every one,
    // so an abandoned request drops mem_req without waiting for an ack.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ioctl_wait <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            mem_din    <= '0;
            loading    <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            ioctl_wait <= wait_nxt;
            mem_req    <= req_nxt;
            mem_addr   <= addr_nxt;
            mem_din    <= din_nxt;
            loading    <= loading_nxt;
            done       <= done_nxt;
            word_count <= count_nxt;
            overrun    <= overrun_nxt;
        end
    end

endmodule

// File: tb/tb_ioctl_sdram_loader.sv
// Directed bench for ioctl_sdram_loader: a scoreboard of expected SDRAM writes is filled as words
// are strobed and drained whenever mem_req rises.
module tb_ioctl_sdram_loader;

    localparam int               ADDR_W = 25;
    localparam logic [ADDR_W-1:0] BASE  = 25'h100000;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [15:0]       data;
    } wr_t;

    logic              clk_sys;
    logic              reset_n;
    logic              ioctl_download;
    logic [7:0]        ioctl_index;
    logic              ioctl_wr;
    logic [ADDR_W-1:0] ioctl_addr;
    logic [15:0]       ioctl_dout;
    logic              ioctl_wait;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_din;
    logic              mem_ack;
    logic              loading;
    logic              done;
    logic [23:0]       word_count;
    logic              overrun;

    logic manual_ack;
    logic auto_ack;
    logic auto_en;
    int   auto_delay;

    wr_t  sb[$];
    int   n_cmp;
    int   n_mis;
    int   done_cnt;
    logic req_prev;

    assign mem_ack = manual_ack | auto_ack;

    ioctl_sdram_loader #(
        .ADDR_W    (ADDR_W),
        .LOAD_INDEX(8'h00),
        .BASE_ADDR (BASE)
    ) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .ioctl_wait    (ioctl_wait),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .mem_ack       (mem_ack),
        .loading       (loading),
        .done          (done),
        .word_count    (word_count),
        .overrun       (overrun)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] s;
        s = BASE + a;
        s[0] = 1'b0;
        return s;
    endfunction

    function automatic logic [15:0] exp_din(input logic [15:0] d);
`ifdef IOCTL_LOADER_BYTESWAP_EN
        return {d[7:0], d[15:8]};
`else
        return d;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Presents one word for a single cycle and records the write it should produce.
    task automatic strobe(input logic [ADDR_W-1:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = exp_addr(a);
        w.data = exp_din(d);
        sb.push_back(w);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ioctl_wait && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(ioctl_wait), 32'd0);
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    // Controller model: acks an outstanding request auto_delay cycles after seeing it.
    initial begin
        int cnt = 0;
        auto_ack = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1;
            if (auto_ack) begin
                auto_ack = 1'b0;
                cnt = 0;
            end else if (auto_en && mem_req) begin
                cnt++;
                if (cnt >= auto_delay) auto_ack = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    // Scoreboard drain on each new request, plus done-pulse counting.
    initial begin
        wr_t w;
        req_prev = 1'b0;
        done_cnt = 0;
        forever begin
            @(negedge clk_sys);
            if (done) done_cnt++;
            if (mem_req && !req_prev) begin
                check("req_has_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    w = sb.pop_front();
                    check("mem_addr", 32'(mem_addr), 32'(w.addr));
                    check("mem_din", 32'(mem_din), 32'(w.data));
                end
            end
            req_prev = mem_req;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cycles;
        int done_base;

        n_cmp = 0;
        n_mis = 0;
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        manual_ack     = 1'b0;
        auto_en        = 1'b0;
        auto_delay     = 2;

        // Reset state
        tick();
        tick();
        check("rst_wait", 32'(ioctl_wait), 32'd0);
        check("rst_req", 32'(mem_req), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_din", 32'(mem_din), 32'd0);
        check("rst_loading", 32'(loading), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single word; a strobe in the first download cycle must be ignored
        ioctl_download = 1'b1;
        ioctl_addr     = 25'h40;
        ioctl_dout     = 16'hDEAD;
        ioctl_wr       = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        check("first_cycle_loading", 32'(loading), 32'd1);
        check("first_cycle_no_req", 32'(mem_req), 32'd0);
        check("first_cycle_no_wait", 32'(ioctl_wait), 32'd0);
        strobe(25'h0, 16'h1234);
        check("t1_req", 32'(mem_req), 32'd1);
        check("t1_din", 32'(mem_din), 32'(exp_din(16'h1234)));
        wait_cycles = 1;
        tick();
        if (ioctl_wait) wait_cycles++;
        tick();
        if (ioctl_wait) wait_cycles++;
        manual_ack = 1'b1;
        tick();
        manual_ack = 1'b0;
        if (ioctl_wait) wait_cycles++;
        check("t1_wait_cycles", 32'(wait_cycles), 32'd3);
        check("t1_req_clear", 32'(mem_req), 32'd0);
        check("t1_count", 32'(word_count), 32'd1);
        ioctl_download = 1'b0;
        tick();
        check("t1_done", 32'(done), 32'd1);
        check("t1_loading_during_done", 32'(loading), 32'd1);
        tick();
        check("t1_done_fall", 32'(done), 32'd0);
        check("t1_loading_fall", 32'(loading), 32'd0);
        check("t1_count_held", 32'(word_count), 32'd1);

        // Four-word stream using the wait handshake
        ioctl_download = 1'b1;
        tick();
        check("t2_count_cleared", 32'(word_count), 32'd0);
        auto_en   = 1'b1;
        done_base = done_cnt;
        for (int i = 0; i < 4; i++) begin
            wait_ready("t2_wait_timeout");
            strobe(ADDR_W'(2 * i), 16'hA000 + 16'(i));
        end
        wait_ready("t2_final_wait_timeout");
        ioctl_download = 1'b0;
        wait_done("t2_done_seen");
        tick();
        tick();
        check("t2_done_pulses", 32'(done_cnt - done_base), 32'd1);
        check("t2_count", 32'(word_count), 32'd4);
        check("t2_loading_fall", 32'(loading), 32'd0);
        auto_en = 1'b0;

        // Wrong index: ignored entirely
        ioctl_index    = 8'h01;
        ioctl_download = 1'b1;
        tick();
        tick();
        ioctl_addr = 25'h10;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        check("t3_no_wait", 32'(ioctl_wait), 32'd0);
        check("t3_no_req", 32'(mem_req), 32'd0);
        check("t3_not_loading", 32'(loading), 32'd0);
        check("t3_count_kept", 32'(word_count), 32'd4);
        ioctl_download = 1'b0;
        ioctl_index    = 8'h00;
        tick();

        // Overrun while busy, odd address, wrapping address
        ioctl_download = 1'b1;
        tick();
        check("t4_overrun_start", 32'(overrun), 32'd0);
        strobe(25'h0000009, 16'h5A5A);
        tick();
        ioctl_addr = 25'h20;
        ioctl_dout = 16'hBEEF;
        ioctl_wr   = 1'b1;
        tick();
        ioctl_wr = 1'b0;
        check("t4_overrun", 32'(overrun), 32'd1);
        check("t4_req_held", 32'(mem_req), 32'd1);
        check("t4_addr_held", 32'(mem_addr), 32'(exp_addr(25'h9)));
        check("t4_din_held", 32'(mem_din), 32'(exp_din(16'h5A5A)));
        manual_ack = 1'b1;
        tick();
        manual_ack = 1'b0;
        check("t4_count", 32'(word_count), 32'd1);
        check("t4_overrun_sticky", 32'(overrun), 32'd1);
        strobe(25'h1F00001, 16'h0F0F);
        check("t4_wrap_addr", 32'(mem_addr), 32'h0);
        manual_ack = 1'b1;
        tick();
        manual_ack = 1'b0;
        check("t4_count2", 32'(word_count), 32'd2);

        // Download falls in the same cycle as the ack
        done_base = done_cnt;
        strobe(25'h30, 16'h7777);
        tick();
        manual_ack     = 1'b1;
        ioctl_download = 1'b0;
        tick();
        manual_ack = 1'b0;
        check("t5_count", 32'(word_count), 32'd3);
        check("t5_req_clear", 32'(mem_req), 32'd0);
        check("t5_done", 32'(done), 32'd1);
        tick();
        check("t5_loading_fall", 32'(loading), 32'd0);
        tick();
        check("t5_done_pulses", 32'(done_cnt - done_base), 32'd1);
        check("t5_overrun_after_load", 32'(overrun), 32'd1);

        // Reset while busy, then a fresh download
        ioctl_download = 1'b1;
        tick();
        check("t6_overrun_cleared", 32'(overrun), 32'd0);
        strobe(25'h50, 16'h1111);
        check("t6_req_before_reset", 32'(mem_req), 32'd1);
        reset_n = 1'b0;
        tick();
        check("t6_req_reset", 32'(mem_req), 32'd0);
        check("t6_wait_reset", 32'(ioctl_wait), 32'd0);
        check("t6_loading_reset", 32'(loading), 32'd0);
        check("t6_count_reset", 32'(word_count), 32'd0);
        reset_n        = 1'b1;
        ioctl_download = 1'b0;
        tick();
        ioctl_download = 1'b1;
        tick();
        auto_en = 1'b1;
        strobe(25'h60, 16'h2222);
        wait_ready("t6_wait_timeout");
        ioctl_download = 1'b0;
        wait_done("t6_done_seen");
        check("t6_count", 32'(word_count), 32'd1);
        auto_en = 1'b0;
        tick();
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
